// File: rtl/hub75_pkg.sv
// Shared HUB75 datapath types: shifter state encoding and packed pixel word field indexing.
// Also used by the row sequencer and the framebuffer writer.
package hub75_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StShift,
      StPulse
   } state_t;

   localparam int unsigned RGB_PER_CHAIN = 6;

   // Bit position of chain c, half h (0 top), channel k (0 R, 1 G, 2 B), bit b in a pixel word.
   function automatic int unsigned fld_idx(input int unsigned c, input int unsigned h,
                                           input int unsigned k, input int unsigned b,
                                           input int unsigned color_bits);
      return ((c * 2 + h) * 3 + k) * color_bits + b;
   endfunction

endpackage

// File: rtl/hub75_plane_mux.sv
// Selects one bit-plane per colour channel from a packed pixel word.
// Out-of-range planes produce all-zero output.
module hub75_plane_mux
   import hub75_pkg::*;
#(
   parameter int unsigned CHAINS     = 2,
   parameter int unsigned COLOR_BITS = 8,
   parameter int unsigned BIT_W      = 3,
   localparam int unsigned DW        = CHAINS * RGB_PER_CHAIN * COLOR_BITS
) (
   input  logic [DW-1:0]                   data,
   input  logic [BIT_W-1:0]                bit_sel,
   output logic [CHAINS*RGB_PER_CHAIN-1:0] rgb
);

   logic plane_ok;

   assign plane_ok = {1'b0, bit_sel} < (BIT_W + 1)'(COLOR_BITS);

   for (genvar c = 0; c < CHAINS; c++) begin : g_chain
      for (genvar h = 0; h < 2; h++) begin : g_half
         for (genvar k = 0; k < 3; k++) begin : g_chan
            localparam int unsigned Base = fld_idx(c, h, k, 0, COLOR_BITS);
            logic [COLOR_BITS-1:0] field;
            assign field = data[Base +: COLOR_BITS];
            assign rgb[c * RGB_PER_CHAIN + h * 3 + k] = plane_ok & field[bit_sel];
         end
      end
   end

endmodule

// File: rtl/hub75_bitplane_shifter.sv
// Column fetch/shift engine: reads one scan row from the framebuffer and shifts one bit-plane
// into CHAINS HUB75 chains. Optional column test pattern: HUB75_TEST_PATTERN_EN.
module hub75_bitplane_shifter
   import hub75_pkg::*;
#(
   parameter int unsigned COLS       = 128,
   parameter int unsigned CHAINS     = 2,
   parameter int unsigned COLOR_BITS = 8,
   parameter int unsigned ROW_W      = 6,
   parameter int unsigned RAM_LAT    = 1,
   localparam int unsigned COL_W     = $clog2(COLS),
   localparam int unsigned BIT_W     = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1,
   localparam int unsigned DW        = CHAINS * RGB_PER_CHAIN * COLOR_BITS
) (
   input  logic                            sys_clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [BIT_W-1:0]                bit_sel,
   input  logic [ROW_W-1:0]                row_sel,
`ifdef HUB75_TEST_PATTERN_EN
   input  logic                            pattern_en,
`endif
   output logic                            busy,
   output logic                            done,
   output logic                            mem_rd,
   output logic [ROW_W+COL_W-1:0]          mem_addr,
   input  logic [DW-1:0]                   mem_data,
   output logic [CHAINS*RGB_PER_CHAIN-1:0] rgb_out,
   output logic                            clk_out
);

   localparam int unsigned LAT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   state_t                          state;
   logic [COL_W-1:0]                col;
   logic [COL_W-1:0]                col_inc;
   logic [BIT_W-1:0]                bit_l;
   logic [ROW_W-1:0]                row_l;
   logic [LAT_W-1:0]                lat;
   logic [CHAINS*RGB_PER_CHAIN-1:0] plane_rgb;
   logic [CHAINS*RGB_PER_CHAIN-1:0] next_rgb;
   logic                            pat_now;

   hub75_plane_mux #(
      .CHAINS     (CHAINS),
      .COLOR_BITS (COLOR_BITS),
      .BIT_W      (BIT_W)
   ) u_plane_mux (
      .data    (mem_data),
      .bit_sel (bit_l),
      .rgb     (plane_rgb)
   );

   // Column counter: cleared while idle, advances on leaving PULSE.
   assign col_inc = col + COL_W'(1);

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         col <= '0;
      end else if (state == StIdle) begin
         col <= '0;
      end else if (state == StPulse) begin
         col <= col_inc;
      end
   end

`ifdef HUB75_TEST_PATTERN_EN
   logic             pat_l;
   logic [COL_W+6:0] col_ext;
   logic [2:0]       pat_rgb;

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         pat_l <= 1'b0;
      end else if (state == StIdle && start) begin
         pat_l <= pattern_en;
      end
   end

   // The read strobe of the first column is issued from IDLE, before pat_l is loaded.
   assign pat_now  = (state == StIdle) ? pattern_en : pat_l;
   assign col_ext  = {7'd0, col};
   assign pat_rgb  = {col_ext[6], col_ext[5], col_ext[4]};
   assign next_rgb = pat_l ? {(CHAINS * 2){pat_rgb}} : plane_rgb;
`else
   assign pat_now  = 1'b0;
   assign next_rgb = plane_rgb;
`endif

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state    <= StIdle;
         busy     <= 1'b0;
         done     <= 1'b0;
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         rgb_out  <= '0;
         clk_out  <= 1'b0;
         bit_l    <= '0;
         row_l    <= '0;
         lat      <= '0;
      end else begin
         done    <= 1'b0;
         mem_rd  <= 1'b0;
         clk_out <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  bit_l    <= bit_sel;
                  row_l    <= row_sel;
                  mem_rd   <= ~pat_now;
                  mem_addr <= {row_sel, {COL_W{1'b0}}};
                  busy     <= 1'b1;
                  state    <= StFetch;
               end
            end
            StFetch: begin
               lat   <= '0;
               state <= StWait;
            end
            StWait: begin
               if (lat == LAT_W'(RAM_LAT - 1)) begin
                  rgb_out <= next_rgb;
                  state   <= StShift;
               end else begin
                  lat <= lat + LAT_W'(1);
               end
            end
            StShift: begin
               clk_out <= 1'b1;
               state   <= StPulse;
            end
            StPulse: begin
               if (col == COL_W'(COLS - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= StIdle;
               end else begin
                  mem_rd   <= ~pat_now;
                  mem_addr <= {row_l, col_inc};
                  state    <= StFetch;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_bitplane_shifter.sv
// Randomized self-checking bench: a default-size instance and a small slow-RAM instance,
// each fed by a behavioural framebuffer, checked against a field-rule reference model.
module tb_hub75_bitplane_shifter;

   localparam int unsigned A_COLS = 128, A_LAT = 1, A_CB = 8, A_CH = 2;
   localparam int unsigned B_COLS = 4, B_LAT = 3, B_CB = 6, B_CH = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic a_start, a_busy, a_done, a_rd, a_clk;
   logic [2:0] a_bit;
   logic [5:0] a_row;
   logic [12:0] a_addr;
   logic [95:0] a_data;
   logic [11:0] a_rgb;
   logic b_start, b_busy, b_done, b_rd, b_clk;
   logic [2:0] b_bit;
   logic [5:0] b_row;
   logic [7:0] b_addr;
   logic [35:0] b_data;
   logic [5:0] b_rgb;
`ifdef HUB75_TEST_PATTERN_EN
   logic a_pat, b_pat;
`endif

   hub75_bitplane_shifter #(
      .COLS(A_COLS), .CHAINS(A_CH), .COLOR_BITS(A_CB), .ROW_W(6), .RAM_LAT(A_LAT)
   ) dut (
      .sys_clk(clk), .rst(rst), .start(a_start), .bit_sel(a_bit), .row_sel(a_row),
`ifdef HUB75_TEST_PATTERN_EN
      .pattern_en(a_pat),
`endif
      .busy(a_busy), .done(a_done), .mem_rd(a_rd), .mem_addr(a_addr), .mem_data(a_data),
      .rgb_out(a_rgb), .clk_out(a_clk)
   );

   hub75_bitplane_shifter #(
      .COLS(B_COLS), .CHAINS(B_CH), .COLOR_BITS(B_CB), .ROW_W(6), .RAM_LAT(B_LAT)
   ) dut_b (
      .sys_clk(clk), .rst(rst), .start(b_start), .bit_sel(b_bit), .row_sel(b_row),
`ifdef HUB75_TEST_PATTERN_EN
      .pattern_en(b_pat),
`endif
      .busy(b_busy), .done(b_done), .mem_rd(b_rd), .mem_addr(b_addr), .mem_data(b_data),
      .rgb_out(b_rgb), .clk_out(b_clk)
   );

   int n_pass = 0;
   int n_total = 0;

   // Framebuffer model: word is a hash of the address, or a forced word.
   logic [31:0] seed;
   logic ovr_en;
   logic [95:0] ovr_word;

   function automatic logic [95:0] ram_word(input logic [12:0] addr);
      logic [95:0] w;
      if (ovr_en) return ovr_word;
      for (int i = 0; i < 3; i++)
         w[i*32 +: 32] = (({19'd0, addr} + 32'(i) * 32'h1F3 + 32'd7) * 32'h9E3779B1) ^ seed;
      return w;
   endfunction

   logic [95:0] a_pipe [A_LAT];
   logic [95:0] b_pipe [B_LAT];
   always @(posedge clk) begin
      a_pipe[0] <= a_rd ? ram_word(a_addr) : '0;
      for (int i = 1; i < A_LAT; i++) a_pipe[i] <= a_pipe[i-1];
      b_pipe[0] <= b_rd ? ram_word({5'd0, b_addr}) : '0;
      for (int i = 1; i < B_LAT; i++) b_pipe[i] <= b_pipe[i-1];
   end
   assign a_data = a_pipe[A_LAT-1];
   assign b_data = b_pipe[B_LAT-1][35:0];

   // Reference: rgb bit (c,h,k) is plane b of field ((c*2+h)*3+k) of the pixel word.
   function automatic logic [11:0] exp_rgb(input logic [95:0] w, input int b, input int chains,
                                           input int cb);
      logic [11:0] r;
      r = '0;
      if (b >= cb) return r;
      for (int c = 0; c < chains; c++)
         for (int h = 0; h < 2; h++)
            for (int k = 0; k < 3; k++) r[c*6 + h*3 + k] = w[((c*2 + h)*3 + k)*cb + b];
      return r;
   endfunction

   // Per-cycle trace of one row, and what was extracted from it.
   logic tr_busy[$], tr_rd[$], tr_clk[$];
   logic [12:0] tr_addr[$];
   logic [11:0] tr_rgb[$];
   int n_busy;
   logic [11:0] p_rgb[$];
   logic [12:0] r_addr[$];
   int p_idx[$], r_idx[$];

   task automatic collect(input bit which, input int max_cycles, output bit timed_out);
      logic d;
      tr_busy.delete(); tr_rd.delete(); tr_clk.delete(); tr_addr.delete(); tr_rgb.delete();
      timed_out = 1'b1;
      for (int n = 0; n < max_cycles; n++) begin
         tr_busy.push_back(which ? b_busy : a_busy);
         tr_rd.push_back(which ? b_rd : a_rd);
         tr_clk.push_back(which ? b_clk : a_clk);
         tr_addr.push_back(which ? 13'(b_addr) : a_addr);
         tr_rgb.push_back(which ? 12'(b_rgb) : a_rgb);
         d = which ? b_done : a_done;
         if (d) begin
            timed_out = 1'b0;
            break;
         end
         @(negedge clk);
      end
      n_busy = 0;
      p_rgb.delete(); r_addr.delete(); p_idx.delete(); r_idx.delete();
      foreach (tr_busy[n]) begin
         if (tr_busy[n]) n_busy++;
         if (tr_clk[n]) begin p_rgb.push_back(tr_rgb[n]); p_idx.push_back(n); end
         if (tr_rd[n]) begin r_addr.push_back(tr_addr[n]); r_idx.push_back(n); end
      end
   endtask

   task automatic kick_a(input logic [5:0] row, input logic [2:0] b);
      @(negedge clk); a_row = row; a_bit = b; a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
   endtask

   task automatic kick_b(input logic [5:0] row, input logic [2:0] b);
      @(negedge clk); b_row = row; b_bit = b; b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      n_total++; if (a_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", a_busy); else n_pass++;
      n_total++; if (a_done !== 1'b0) $display("FAIL rst_done got %b want 0", a_done); else n_pass++;
      n_total++; if (a_rd !== 1'b0) $display("FAIL rst_rd got %b want 0", a_rd); else n_pass++;
      n_total++; if (a_addr !== '0) $display("FAIL rst_addr got %h want 0", a_addr); else n_pass++;
      n_total++; if (a_rgb !== '0) $display("FAIL rst_rgb got %h want 0", a_rgb); else n_pass++;
      n_total++; if (a_clk !== 1'b0) $display("FAIL rst_clk got %b want 0", a_clk); else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_row(input logic [5:0] row, input logic [2:0] b);
      bit to;
      seed = $urandom;
      kick_a(row, b);
      collect(1'b0, 700, to);
      n_total++; if (to) $display("FAIL row_done_timeout got none want done"); else n_pass++;
      n_total++; if (p_rgb.size() !== 128) $display("FAIL row_pulses got %0d want 128", p_rgb.size());
      else n_pass++;
      n_total++; if (n_busy !== 512) $display("FAIL row_busy got %0d want 512", n_busy); else n_pass++;
      n_total++; if (r_addr.size() !== 128) $display("FAIL row_reads got %0d want 128", r_addr.size());
      else n_pass++;
      for (int i = 0; i < r_addr.size() && i < 128; i++) begin
         n_total++;
         if (r_addr[i] !== 13'(row * 128 + i))
            $display("FAIL row_addr[%0d] got %h want %h", i, r_addr[i], 13'(row * 128 + i));
         else n_pass++;
      end
      for (int i = 0; i < p_rgb.size() && i < 128; i++) begin
         n_total++;
         if (p_rgb[i] !== exp_rgb(ram_word(13'(row * 128 + i)), b, A_CH, A_CB))
            $display("FAIL row_rgb[%0d] got %h want %h", i, p_rgb[i],
                     exp_rgb(ram_word(13'(row * 128 + i)), b, A_CH, A_CB));
         else n_pass++;
      end
      @(negedge clk);
      n_total++; if (a_done !== 1'b0) $display("FAIL done_width got %b want 0", a_done); else n_pass++;
   endtask

   task automatic test_bit_sweep();
      bit to;
      logic [7:0] a5;
      a5 = 8'hA5;
      ovr_en = 1'b1;
      ovr_word = {$urandom, $urandom, $urandom};
      ovr_word[7:0] = a5;
      for (int b = 0; b < 8; b++) begin
         kick_a(6'd3, 3'(b));
         collect(1'b0, 700, to);
         n_total++;
         if (to || p_rgb.size() == 0) $display("FAIL sweep_run[%0d] got no pulses want 128", b);
         else n_pass++;
         if (p_rgb.size() > 0) begin
            n_total++;
            if (p_rgb[0][0] !== a5[b]) $display("FAIL sweep_r0[%0d] got %b want %b", b, p_rgb[0][0], a5[b]);
            else n_pass++;
            n_total++;
            if (p_rgb[0] !== exp_rgb(ovr_word, b, A_CH, A_CB))
               $display("FAIL sweep_rgb[%0d] got %h want %h", b, p_rgb[0], exp_rgb(ovr_word, b, A_CH, A_CB));
            else n_pass++;
         end
      end
      ovr_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit to;
      logic [5:0] r1, r2;
      seed = $urandom;
      r1 = 6'($urandom_range(0, 63));
      r2 = r1 ^ 6'h2A;
      @(negedge clk); a_row = r1; a_bit = 3'($urandom_range(0, 7)); a_start = 1'b1;
      @(negedge clk);
      fork
         collect(1'b0, 700, to);
         begin
            repeat (50) @(negedge clk);
            a_row = r2;
            repeat (100) @(negedge clk);
            a_start = 1'b0;
            @(negedge clk);
            a_start = 1'b1;
         end
      join
      n_total++; if (to) $display("FAIL b2b_timeout got none want done"); else n_pass++;
      n_total++; if (p_rgb.size() !== 128) $display("FAIL b2b_pulses got %0d want 128", p_rgb.size());
      else n_pass++;
      n_total++; if (n_busy !== 512) $display("FAIL b2b_busy got %0d want 512", n_busy); else n_pass++;
      for (int i = 0; i < r_addr.size(); i++) begin
         n_total++;
         if (r_addr[i] !== 13'(r1 * 128 + i))
            $display("FAIL b2b_addr[%0d] got %h want %h", i, r_addr[i], 13'(r1 * 128 + i));
         else n_pass++;
      end
      @(negedge clk);
      n_total++; if (a_busy !== 1'b1) $display("FAIL b2b_restart_busy got %b want 1", a_busy); else n_pass++;
      n_total++; if (a_rd !== 1'b1) $display("FAIL b2b_restart_rd got %b want 1", a_rd); else n_pass++;
      n_total++;
      if (a_addr !== 13'(r2 * 128)) $display("FAIL b2b_restart_addr got %h want %h", a_addr, 13'(r2 * 128));
      else n_pass++;
      a_start = 1'b0;
      collect(1'b0, 700, to);
      n_total++; if (to || r_addr.size() !== 128) $display("FAIL b2b_row2 got %0d reads want 128", r_addr.size());
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit to;
      int pulses, dones;
      seed = $urandom;
      kick_a(6'd9, 3'($urandom_range(0, 7)));
      pulses = 0;
      for (int n = 0; n < 1000 && pulses < 38; n++) begin
         if (a_clk) pulses++;
         if (pulses < 38) @(negedge clk);
      end
      n_total++; if (pulses !== 38) $display("FAIL mid_reach_col37 got %0d want 38", pulses); else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_total++; if ({a_busy, a_done, a_rd, a_clk} !== 4'b0)
         $display("FAIL mid_rst_flags got %b want 0000", {a_busy, a_done, a_rd, a_clk}); else n_pass++;
      n_total++; if (a_addr !== '0) $display("FAIL mid_rst_addr got %h want 0", a_addr); else n_pass++;
      n_total++; if (a_rgb !== '0) $display("FAIL mid_rst_rgb got %h want 0", a_rgb); else n_pass++;
      rst = 1'b0;
      dones = 0;
      repeat (20) begin @(negedge clk); if (a_done) dones++; end
      n_total++; if (dones !== 0) $display("FAIL mid_no_done got %0d want 0", dones); else n_pass++;
      kick_a(6'd9, 3'd1);
      n_total++; if (a_addr !== 13'(9 * 128)) $display("FAIL mid_restart_addr got %h want %h", a_addr, 13'(9 * 128));
      else n_pass++;
      collect(1'b0, 700, to);
      n_total++; if (to || p_rgb.size() !== 128) $display("FAIL mid_restart_pulses got %0d want 128", p_rgb.size());
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_latency_b();
      bit to;
      logic [5:0] row;
      int b;
      seed = $urandom;
      row = 6'($urandom_range(0, 63));
      b = $urandom_range(0, 5);
      kick_b(row, 3'(b));
      collect(1'b1, 100, to);
      n_total++; if (to) $display("FAIL lat_timeout got none want done"); else n_pass++;
      n_total++; if (p_rgb.size() !== 4) $display("FAIL lat_pulses got %0d want 4", p_rgb.size()); else n_pass++;
      n_total++; if (n_busy !== 24) $display("FAIL lat_busy got %0d want 24", n_busy); else n_pass++;
      for (int i = 1; i < r_idx.size(); i++) begin
         n_total++;
         if (r_idx[i] - r_idx[i-1] !== 6) $display("FAIL lat_period[%0d] got %0d want 6", i, r_idx[i] - r_idx[i-1]);
         else n_pass++;
      end
      for (int i = 0; i < p_rgb.size(); i++) begin
         n_total++;
         if (p_rgb[i] !== exp_rgb(ram_word(13'(row * 4 + i)), b, B_CH, B_CB))
            $display("FAIL lat_rgb[%0d] got %h want %h", i, p_rgb[i],
                     exp_rgb(ram_word(13'(row * 4 + i)), b, B_CH, B_CB));
         else n_pass++;
      end
      for (int n = 1; n < tr_rgb.size(); n++) begin
         if (tr_clk[n]) begin
            n_total++;
            if (tr_rgb[n] !== tr_rgb[n-1]) $display("FAIL lat_stable_hi[%0d] got %h want %h", n, tr_rgb[n], tr_rgb[n-1]);
            else n_pass++;
         end
         if (tr_rgb[n] !== tr_rgb[n-1]) begin
            n_total++;
            if (n + 1 >= tr_clk.size() || tr_clk[n+1] !== 1'b1)
               $display("FAIL lat_change_at[%0d] got not-shift want shift entry", n);
            else n_pass++;
         end
      end
      @(negedge clk);
   endtask

   task automatic test_bit_oob_b();
      bit to;
      ovr_en = 1'b1;
      ovr_word = '1;
      kick_b(6'd2, 3'd6);
      collect(1'b1, 100, to);
      n_total++; if (to || p_rgb.size() !== 4) $display("FAIL oob_pulses got %0d want 4", p_rgb.size()); else n_pass++;
      foreach (p_rgb[i]) begin
         n_total++; if (p_rgb[i] !== '0) $display("FAIL oob_rgb[%0d] got %h want 0", i, p_rgb[i]); else n_pass++;
      end
      @(negedge clk);
      kick_b(6'd2, 3'd5);
      collect(1'b1, 100, to);
      n_total++; if (p_rgb.size() == 0 || p_rgb[0] !== 12'h03F)
         $display("FAIL top_plane_rgb got %h want 03f", p_rgb.size() > 0 ? p_rgb[0] : 12'h0); else n_pass++;
      ovr_en = 1'b0;
      @(negedge clk);
   endtask

`ifdef HUB75_TEST_PATTERN_EN
   task automatic test_pattern();
      bit to;
      logic [11:0] e;
      logic [31:0] iv;
      a_pat = 1'b1;
      kick_a(6'd4, 3'd0);
      a_pat = 1'b0;
      collect(1'b0, 700, to);
      n_total++; if (r_addr.size() !== 0) $display("FAIL pat_reads got %0d want 0", r_addr.size()); else n_pass++;
      n_total++; if (to || p_rgb.size() !== 128) $display("FAIL pat_pulses got %0d want 128", p_rgb.size());
      else n_pass++;
      for (int i = 0; i < p_rgb.size(); i++) begin
         iv = 32'(i);
         e = {4{iv[6], iv[5], iv[4]}};
         n_total++; if (p_rgb[i] !== e) $display("FAIL pat_rgb[%0d] got %h want %h", i, p_rgb[i], e); else n_pass++;
      end
      if (p_rgb.size() > 48) begin
         n_total++; if (p_rgb[48] !== {4{3'b011}}) $display("FAIL pat_col48 got %h want 6db", p_rgb[48]);
         else n_pass++;
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      rst = 1'b1;
      a_start = 1'b0; a_bit = '0; a_row = '0;
      b_start = 1'b0; b_bit = '0; b_row = '0;
`ifdef HUB75_TEST_PATTERN_EN
      a_pat = 1'b0; b_pat = 1'b0;
`endif
      ovr_en = 1'b0; ovr_word = '0; seed = '0;
      test_reset();
      test_row(6'd5, 3'd0);
      test_row(6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
      test_row(6'($urandom_range(0, 63)), 3'($urandom_range(0, 7)));
      test_bit_sweep();
      test_back_to_back();
      test_reset_mid();
      test_latency_b();
      test_bit_oob_b();
`ifdef HUB75_TEST_PATTERN_EN
      test_pattern();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
